bus_ram_responder: RTL and testbench

- Responder (target) end of the CPU's request/ready memory bus.
- Holds a word-addressed on-chip RAM, decoded at a base address, with a programmable number of wait states.
- Answers read and write requests from the initiator using a level (four-phase) handshake.
- Sits between the CPU bus port and the program/data memory; it is also the reference target for bus verification.

---
 rtl/bus_ram_responder.sv | 129 ++++++++++++
 tb/tb_bus_ram_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ram_responder.sv
// bus_ram_responder
//   Target end of the CPU request/ready memory bus. It holds a word-addressed
//   on-chip RAM decoded at BASE, adds WAIT_STATES extra cycles before it
//   acknowledges, and answers with a level (four-phase) handshake.
//
// Ports
//   i_clock    : clock, all state changes on the rising edge
//   i_reset_n  : asynchronous active-low reset
//   i_request  : initiator request, held high until o_ready is seen
//   i_rw       : 0 = read, 1 = write, captured with the request
//   i_address  : byte address, bits [1:0] ignored, captured with the request
//   i_data     : write data, captured with the request
//   o_ready    : transaction complete / read data valid
//   o_data     : read data, meaningful only while o_ready is high
module bus_ram_responder #(
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_data,
  output logic        o_ready,
  output logic [31:0] o_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t               state;
  logic [3:0]           wait_cnt;
  logic                 aborted;

  logic                 rw_p0;
  logic                 hit_p0;
  logic [ADDR_BITS-1:0] index_p0;
  logic [31:0]          wdata_p0;

  logic [31:0]          mem [DEPTH];

  logic [31:0]          offset;
  logic                 hit;
  logic                 commit;
  logic                 unused_offset_bits;

  // BASE is 4*DEPTH aligned, so an address below BASE wraps to a large
  // offset and fails the same upper-bits test as one above the window.
  assign offset             = i_address - BASE;
  assign hit                = (offset[31:ADDR_BITS+2] == '0);
  assign unused_offset_bits = ^offset[1:0];

  assign commit = (state == S_WAIT) && (wait_cnt == 4'd0);

  // Stage p0: request capture; later changes on the bus have no effect
  always_ff @(posedge i_clock) begin
    if (state == S_IDLE && i_request) begin
      rw_p0    <= i_rw;
      hit_p0   <= hit;
      index_p0 <= offset[ADDR_BITS+1:2];
      wdata_p0 <= i_data;
    end
  end

  // Commit edge: writes land here even if the request was withdrawn.
  // Out-of-range writes are dropped so they never alias onto the array.
  always_ff @(posedge i_clock) begin
    if (commit && rw_p0 && hit_p0) begin
      mem[index_p0] <= wdata_p0;
    end
  end

  // Handshake control and registered outputs
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      aborted  <= 1'b0;
      o_ready  <= 1'b0;
      o_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_request) begin
            wait_cnt <= 4'(WAIT_STATES);
            aborted  <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
            if (!i_request) begin
              aborted <= 1'b1;
            end
          end else begin
            if (!rw_p0) begin
              o_data <= hit_p0 ? mem[index_p0] : '0;
            end
            // A request that dropped at any point in the wait finishes
            // silently instead of acknowledging a departed initiator.
            if (i_request && !aborted) begin
              o_ready <= 1'b1;
              state   <= S_ACK;
            end else begin
              state   <= S_IDLE;
            end
          end
        end
        S_ACK: begin
          if (!i_request) begin
            o_ready <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ram_responder.sv
// tb_bus_ram_responder
//   Drives three responders (WAIT_STATES = 1, 0, 3) from one shared bus and
//   checks them against a transaction-level model of the handshake timing and
//   the RAM contents, plus hand-computed latencies and data words.
module tb_bus_ram_responder;

  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          DEPTH     = 1024;
  localparam int          ADDR_BITS = 10;
  localparam int          WS [3]    = '{1, 0, 3};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req   = 1'b0;
  logic        rw_i  = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdat  = '0;

  logic        rdy  [3];
  logic [31:0] dout [3];

  int          checks   = 0;
  int          failures = 0;

  int          lat [3];
  logic [31:0] got [3];
  int          exp_lat [3] = '{2, 1, 4};

  always #5 clk = ~clk;

  bus_ram_responder #(.BASE(BASE), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS), .WAIT_STATES(WS[0])) u_ws1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_request(req), .i_rw(rw_i),
    .i_address(addr), .i_data(wdat), .o_ready(rdy[0]), .o_data(dout[0])
  );
  bus_ram_responder #(.BASE(BASE), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS), .WAIT_STATES(WS[1])) u_ws0 (
    .i_clock(clk), .i_reset_n(rst_n), .i_request(req), .i_rw(rw_i),
    .i_address(addr), .i_data(wdat), .o_ready(rdy[1]), .o_data(dout[1])
  );
  bus_ram_responder #(.BASE(BASE), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS), .WAIT_STATES(WS[2])) u_ws3 (
    .i_clock(clk), .i_reset_n(rst_n), .i_request(req), .i_rw(rw_i),
    .i_address(addr), .i_data(wdat), .o_ready(rdy[2]), .o_data(dout[2])
  );

  task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, actual, required);
    end
  endtask

  // ---------------- model: one outstanding transaction per responder ----------------
  int          cyc = 0;
  bit          busy [3];
  bit          acked [3];
  bit          gave_up [3];
  int          commit_at [3];
  bit          exp_rdy [3];
  logic [31:0] exp_dat [3];
  bit          t_rw [3];
  logic [31:0] t_addr [3];
  logic [31:0] t_wd [3];
  logic [31:0] mmem [int];

  function automatic bit in_ram(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int key_of(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return d * DEPTH + int'(off);
  endfunction

  always begin
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        busy[d]    = 1'b0;
        exp_rdy[d] = 1'b0;
        exp_dat[d] = '0;
      end else if (!busy[d]) begin
        if (req) begin
          busy[d]      = 1'b1;
          acked[d]     = 1'b0;
          gave_up[d]   = 1'b0;
          commit_at[d] = cyc + 1 + WS[d];
          t_rw[d]      = rw_i;
          t_addr[d]    = addr;
          t_wd[d]      = wdat;
        end
      end else if (!acked[d]) begin
        if (!req) gave_up[d] = 1'b1;
        if (cyc == commit_at[d]) begin
          if (t_rw[d]) begin
            if (in_ram(t_addr[d])) mmem[key_of(d, t_addr[d])] = t_wd[d];
          end else begin
            exp_dat[d] = in_ram(t_addr[d]) ? mmem[key_of(d, t_addr[d])] : 32'h0;
          end
          if (gave_up[d]) begin
            busy[d] = 1'b0;
          end else begin
            acked[d]   = 1'b1;
            exp_rdy[d] = 1'b1;
          end
        end
      end else if (!req) begin
        exp_rdy[d] = 1'b0;
        busy[d]    = 1'b0;
      end
      chk($sformatf("ready_ws%0d", WS[d]), 32'(rdy[d]), 32'(exp_rdy[d]));
      if (exp_rdy[d] && !t_rw[d]) begin
        chk($sformatf("data_ws%0d", WS[d]), dout[d], exp_dat[d]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input bit rw, input logic [31:0] a, input logic [31:0] wd, input int hold);
    int k;
    bit all;
    @(negedge clk);
    req  = 1'b1;
    rw_i = rw;
    addr = a;
    wdat = wd;
    for (int d = 0; d < 3; d++) lat[d] = -1;
    k   = 0;
    all = 1'b0;
    while (!all && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      all = 1'b1;
      for (int d = 0; d < 3; d++) begin
        if (rdy[d] && lat[d] < 0) lat[d] = k - 1;
        if (lat[d] < 0) all = 1'b0;
      end
    end
    chk("handshake_done", 32'(all), 32'd1);
    // Bus contents change while the request is still held.
    @(negedge clk);
    rw_i = ~rw;
    addr = 32'h0000_0FFC;
    wdat = 32'h0BAD_0BAD;
    repeat (hold) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) got[d] = dout[d];
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("ready_drop_ws%0d", WS[d]), 32'(rdy[d]), 32'd0);
  endtask

  task automatic chk_lat(input string nm);
    for (int d = 0; d < 3; d++) chk($sformatf("%s_lat_ws%0d", nm, WS[d]), 32'(lat[d]), 32'(exp_lat[d]));
  endtask

  task automatic chk_got(input string nm, input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    chk($sformatf("%s_ws%0d", nm, WS[0]), got[0], v0);
    chk($sformatf("%s_ws%0d", nm, WS[1]), got[1], v1);
    chk($sformatf("%s_ws%0d", nm, WS[2]), got[2], v2);
  endtask

  initial begin
    int n_rdy;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_ready_ws%0d", WS[d]), 32'(rdy[d]), 32'd0);
      chk($sformatf("reset_data_ws%0d", WS[d]), dout[d], 32'd0);
    end
    rst_n = 1'b1;

    // write then read back, read held 5 extra cycles in ACK
    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
    chk_lat("wr10");
    xact(1'b0, 32'h10, 32'h0, 5);
    chk_lat("rd10");
    chk_got("rd10", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // out of range: read returns zero, write does not alias onto index 0
    xact(1'b1, 32'h0, 32'hCAFE_0000, 0);
    xact(1'b0, 32'h1000, 32'h0, 1);
    chk_lat("rd_oor");
    chk_got("rd_oor", 32'h0, 32'h0, 32'h0);
    xact(1'b1, 32'h1000, 32'h1234, 0);
    chk_lat("wr_oor");
    xact(1'b0, 32'h0, 32'h0, 0);
    chk_got("rd_idx0", 32'hCAFE_0000, 32'hCAFE_0000, 32'hCAFE_0000);

    // low address bits ignored
    xact(1'b1, 32'h23, 32'hA5A5_A5A5, 0);
    xact(1'b0, 32'h20, 32'h0, 2);
    chk_got("rd20", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

    // abort: request dropped after one cycle, write still lands, no ready
    @(negedge clk);
    req  = 1'b1;
    rw_i = 1'b1;
    addr = 32'h8;
    wdat = 32'h55;
    @(negedge clk);
    req = 1'b0;
    n_rdy = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) if (rdy[d]) n_rdy++;
    end
    chk("abort_ready_count", 32'(n_rdy), 32'd0);
    xact(1'b0, 32'h8, 32'h0, 0);
    chk_got("rd8", 32'h55, 32'h55, 32'h55);

    // reset one cycle before the WAIT_STATES=3 commit
    xact(1'b1, 32'hC, 32'h11, 0);
    @(negedge clk);
    req  = 1'b1;
    rw_i = 1'b1;
    addr = 32'hC;
    wdat = 32'h77;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("rst_mid_ready_ws%0d", WS[d]), 32'(rdy[d]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 32'hC, 32'h0, 0);
    chk_got("rdC", 32'h77, 32'h77, 32'h11);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
